// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the NES OAM sprite-DMA sequencer.
// The optional OAM_DMA_STATS_EN statistics feature uses the stall-length constants.
package oam_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] TRIGGER_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;
  localparam int          XFER_LEN_DEF      = 256;

  // Total cycles with cpu_stall high for a full 256-byte transfer
  localparam logic [9:0] STALL_EVEN = 10'd513;
  localparam logic [9:0] STALL_ODD  = 10'd514;

endpackage

// File: rtl/oam_dma_sequencer_if.sv
// CPU-side and decoder-side bus bundle for oam_dma_sequencer.
// Defining OAM_DMA_STATS_EN adds the xfer_count/last_stall statistics outputs.
interface oam_dma_sequencer_if;

  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  bus_rdata;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_wdata;
  logic        cpu_stall;
  logic        busy;
`ifdef OAM_DMA_STATS_EN
  logic [15:0] xfer_count;
  logic [9:0]  last_stall;

  modport master (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata, bus_rdata,
    output bus_addr, bus_rd, bus_wr, bus_wdata, cpu_stall, busy,
    output xfer_count, last_stall
  );

  modport slave (
    output cpu_addr, cpu_rd, cpu_wr, cpu_wdata, bus_rdata,
    input  bus_addr, bus_rd, bus_wr, bus_wdata, cpu_stall, busy,
    input  xfer_count, last_stall
  );
`else
  modport master (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata, bus_rdata,
    output bus_addr, bus_rd, bus_wr, bus_wdata, cpu_stall, busy
  );

  modport slave (
    output cpu_addr, cpu_rd, cpu_wr, cpu_wdata, bus_rdata,
    input  bus_addr, bus_rd, bus_wr, bus_wdata, cpu_stall, busy
  );
`endif

endinterface

// File: rtl/oam_dma_sequencer.sv
// NES $4014 sprite DMA: stalls the CPU and copies page $PP00-$PPFF into OAM via $2004.
// Optional statistics outputs are enabled with OAM_DMA_STATS_EN.
module oam_dma_sequencer
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR  = TRIGGER_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF,
  parameter int          XFER_LEN      = XFER_LEN_DEF
) (
  input logic               clk,
  input logic               rst,
  oam_dma_sequencer_if.master dma
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t state;
  dma_state_t next_state;
  logic       par;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] latch;
  logic       trigger;
  logic       last_write;

  assign trigger    = (state == IDLE) && dma.cpu_wr && (dma.cpu_addr == TRIGGER_ADDR);
  assign last_write = (state == WRITE) && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      par   <= 1'b0;
      page  <= '0;
      idx   <= '0;
      latch <= '0;
    end else begin
      state <= next_state;
      par   <= ~par;
      if (trigger) begin
        page <= dma.cpu_wdata;
        idx  <= '0;
      end
      if (state == READ) begin
        latch <= dma.bus_rdata;
      end
      // idx wraps within the page and never carries into it
      if (state == WRITE) begin
        idx <= last_write ? 8'd0 : idx + 8'd1;
      end
    end
  end

  always_comb begin
    next_state    = state;
    dma.bus_addr  = {page, idx};
    dma.bus_rd    = 1'b0;
    dma.bus_wr    = 1'b0;
    dma.bus_wdata = latch;
    dma.cpu_stall = 1'b1;
    dma.busy      = 1'b1;
    case (state)
      IDLE: begin
        dma.bus_addr  = dma.cpu_addr;
        dma.bus_rd    = dma.cpu_rd;
        dma.bus_wr    = dma.cpu_wr;
        dma.bus_wdata = dma.cpu_wdata;
        dma.cpu_stall = 1'b0;
        dma.busy      = 1'b0;
        if (trigger) begin
          next_state = HALT;
        end
      end
      // READ must land on a get cycle (par=0)
      HALT:  next_state = par ? READ : ALIGN;
      ALIGN: next_state = READ;
      READ: begin
        dma.bus_rd = 1'b1;
        next_state = WRITE;
      end
      WRITE: begin
        dma.bus_addr = OAM_DATA_ADDR;
        dma.bus_wr   = 1'b1;
        next_state   = last_write ? IDLE : READ;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef OAM_DMA_STATS_EN
  logic aligned;

  // An ALIGN cycle was inserted when HALT fell on a get cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      aligned        <= 1'b0;
      dma.xfer_count <= '0;
      dma.last_stall <= '0;
    end else begin
      if (state == HALT) begin
        aligned <= ~par;
      end
      if (last_write) begin
        if (dma.xfer_count != 16'hFFFF) begin
          dma.xfer_count <= dma.xfer_count + 16'd1;
        end
        dma.last_stall <= aligned ? STALL_ODD : STALL_EVEN;
      end
    end
  end
`endif

endmodule

// File: tb/tb_oam_dma_sequencer.sv
// Randomized self-checking bench for oam_dma_sequencer against a transfer-level model.
// Statistics checks are compiled in when OAM_DMA_STATS_EN is defined.
module tb_oam_dma_sequencer;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic model_par;
  logic [7:0] mem [0:65535];

  oam_dma_sequencer_if dma_if ();

  oam_dma_sequencer dut (
    .clk (clk),
    .rst (rst),
    .dma (dma_if)
  );

  assign dma_if.bus_rdata = mem[dma_if.bus_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Get/put parity as the NES defines it: toggles every cycle, zero after reset
  always @(posedge clk) model_par <= rst ? 1'b0 : ~model_par;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic rd, input logic wr,
                               input logic [7:0] wdata);
    dma_if.cpu_addr  = addr;
    dma_if.cpu_rd    = rd;
    dma_if.cpu_wr    = wr;
    dma_if.cpu_wdata = wdata;
    @(negedge clk);
    checkOutput("pass_addr", dma_if.bus_addr, addr);
    checkOutput("pass_rd", dma_if.bus_rd, rd);
    checkOutput("pass_wr", dma_if.bus_wr, wr);
    checkOutput("pass_wdata", dma_if.bus_wdata, wdata);
    checkOutput("pass_stall", dma_if.cpu_stall, 0);
    checkOutput("pass_busy", dma_if.busy, 0);
    nextCycle();
  endtask

  task automatic waitPar(input logic p);
    while (model_par != p) nextCycle();
  endtask

  // One transfer of page pg; abort_at >= 0 pulses rst during that write
  task automatic runTransfer(input logic [7:0] pg, input int abort_at);
    logic trig_par;
    int   exp_stall, exp_lat;
    int   cycles, stall_cycles, rd_idx, wr_idx, first_rd;
    logic done, aborted;
    trig_par  = model_par;
    exp_stall = trig_par ? 514 : 513;
    exp_lat   = trig_par ? 3 : 2;
    dma_if.cpu_addr  = 16'h4014;
    dma_if.cpu_rd    = 1'b0;
    dma_if.cpu_wr    = 1'b1;
    dma_if.cpu_wdata = pg;
    @(negedge clk);
    checkOutput("trig_addr", dma_if.bus_addr, 16'h4014);
    checkOutput("trig_wr", dma_if.bus_wr, 1);
    checkOutput("trig_stall", dma_if.cpu_stall, 0);
    nextCycle();
    cycles = 0; stall_cycles = 0; rd_idx = 0; wr_idx = 0; first_rd = -1;
    done = 1'b0; aborted = 1'b0;
    while (!done && !aborted && cycles < 700) begin
      if (cycles < exp_stall) begin
        dma_if.cpu_addr  = ($urandom_range(0, 3) == 0) ? 16'h4014 : 16'($urandom);
        dma_if.cpu_rd    = 1'($urandom);
        dma_if.cpu_wr    = 1'($urandom);
        dma_if.cpu_wdata = 8'($urandom);
      end else begin
        dma_if.cpu_addr = 16'h0000;
        dma_if.cpu_rd   = 1'b0;
        dma_if.cpu_wr   = 1'b0;
      end
      @(negedge clk);
      cycles++;
      if (!dma_if.cpu_stall) begin
        done = 1'b1;
        checkOutput("end_busy", dma_if.busy, 0);
        checkOutput("end_bus_rd", dma_if.bus_rd, 0);
        checkOutput("end_bus_wr", dma_if.bus_wr, 0);
      end else begin
        stall_cycles++;
        if (dma_if.bus_rd) begin
          if (first_rd < 0) first_rd = cycles;
          checkOutput("rd_addr", dma_if.bus_addr, {pg, 8'(rd_idx)});
          checkOutput("rd_par", model_par, 0);
          rd_idx++;
        end
        if (dma_if.bus_wr) begin
          checkOutput("wr_addr", dma_if.bus_addr, 16'h2004);
          checkOutput("wr_data", dma_if.bus_wdata, mem[{pg, 8'(wr_idx)}]);
          if (wr_idx == abort_at) begin
            rst = 1'b1;
            aborted = 1'b1;
          end
          wr_idx++;
        end
      end
      nextCycle();
    end
    if (aborted) begin
      rst = 1'b0;
      dma_if.cpu_addr = 16'h0000;
      dma_if.cpu_rd   = 1'b0;
      dma_if.cpu_wr   = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checkOutput("abort_stall", dma_if.cpu_stall, 0);
        checkOutput("abort_busy", dma_if.busy, 0);
        checkOutput("abort_wr", dma_if.bus_wr, 0);
        nextCycle();
      end
    end else begin
      if (!done) checkOutput("timeout", 1, 0);
      checkOutput("stall_len", stall_cycles, exp_stall);
      checkOutput("rd_latency", first_rd, exp_lat);
      checkOutput("rd_count", rd_idx, 256);
      checkOutput("wr_count", wr_idx, 256);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    dma_if.cpu_addr  = 16'h0000;
    dma_if.cpu_rd    = 1'b0;
    dma_if.cpu_wr    = 1'b0;
    dma_if.cpu_wdata = 8'h00;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    #1;
    doReset();
    @(negedge clk);
    checkOutput("rst_stall", dma_if.cpu_stall, 0);
    checkOutput("rst_busy", dma_if.busy, 0);
    nextCycle();

    // Passthrough in IDLE, including the canonical $2002 read / $2000 write
    applyStimulus(16'h2002, 1'b1, 1'b0, 8'h00);
    applyStimulus(16'h2000, 1'b0, 1'b1, 8'h55);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] a;
      a = 16'($urandom);
      if (a == 16'h4014) a = 16'h4015;
      applyStimulus(a, 1'($urandom), 1'($urandom), 8'($urandom));
    end

    // Even alignment, then odd alignment
    waitPar(1'b0);
    runTransfer(8'h02, -1);
    waitPar(1'b1);
    runTransfer(8'h02, -1);

    // Page wrap
    runTransfer(8'hFF, -1);
    applyStimulus(16'h1234, 1'b0, 1'b0, 8'h00);

    // Abort mid-transfer, then a clean transfer
    runTransfer(8'($urandom), 100);
    runTransfer(8'h03, -1);

    // Random pages and alignments
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) nextCycle();
      runTransfer(8'($urandom), -1);
    end

`ifdef OAM_DMA_STATS_EN
    doReset();
    @(negedge clk);
    checkOutput("stats_rst_count", dma_if.xfer_count, 0);
    checkOutput("stats_rst_stall", dma_if.last_stall, 0);
    nextCycle();
    waitPar(1'b0);
    runTransfer(8'h10, -1);
    @(negedge clk);
    checkOutput("stats_count1", dma_if.xfer_count, 1);
    checkOutput("stats_stall1", dma_if.last_stall, 513);
    nextCycle();
    waitPar(1'b1);
    runTransfer(8'h11, -1);
    @(negedge clk);
    checkOutput("stats_count2", dma_if.xfer_count, 2);
    checkOutput("stats_stall2", dma_if.last_stall, 514);
    nextCycle();
    waitPar(1'b0);
    runTransfer(8'h12, 40);
    @(negedge clk);
    checkOutput("stats_abort_count", dma_if.xfer_count, 0);
    checkOutput("stats_abort_stall", dma_if.last_stall, 0);
    nextCycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
